uc_booth: RTL and testbench

//  Control unit (uc) for the radix-2 Booth multiplier datapath (cd).
//  - Sequences load, add/subtract and arithmetic-shift steps over N iterations.
//  - Samples cd feedback bits Q[0] and q_menos1.
//  - start/Fin handshake toward the system.
//  - Product is left in cd registers {A,Q}; this block never touches data bits.

---
 rtl/uc_booth_pkg.sv | 7 +
 rtl/uc_booth_contador_iter.sv | 19 +
 rtl/uc_booth.sv | 58 +++++
 tb/tb_uc_booth.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/uc_booth_pkg.sv
// uc_booth_pkg: state encoding, Booth step codes and default width for the Booth control unit
package uc_booth_pkg;
   localparam int N_DEF = 3;
   localparam logic [1:0] SUMA  = 2'b01;
   localparam logic [1:0] RESTA = 2'b10;
   typedef enum logic [2:0] {REPOSO, CARGA, EVALUA, DESPLAZA, FIN} estado_t;
endpackage

// File: rtl/uc_booth_contador_iter.sv
// contador_iter: iteration down-counter with load, guarded decrement and last-iteration flag
module contador_iter #(
   parameter int N     = 3,
   parameter int CNT_W = $clog2(N+1)
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic dec,
   output logic ultimo
);
   logic [CNT_W-1:0] cnt;
   // load has priority; decrement stops at zero so the count never wraps
   always_ff @(posedge clk or negedge reset)
      if (!reset) cnt <= '0;
      else if (load) cnt <= CNT_W'(N);
      else if (dec && cnt != '0) cnt <= cnt - CNT_W'(1);
   assign ultimo = cnt == CNT_W'(1);
endmodule

// File: rtl/uc_booth.sv
// uc_booth: control unit sequencing load, add/subtract and shift steps of a radix-2 Booth multiplier
module uc_booth
   import uc_booth_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int CNT_W = $clog2(N+1)
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic q0,
   input  logic q_menos1,
   output logic Carga_A,
   output logic Carga_QM,
   output logic Inicializa,
   output logic Desplaza_AQ,
   output logic Desplaza_M,
   output logic Resta,
   output logic Fin
);
   estado_t estado, siguiente;
   logic ultimo;
   logic [1:0] codigo;
   assign codigo = {q0, q_menos1};
   contador_iter #(.N(N), .CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .load  (estado == CARGA),
      .dec   (estado == DESPLAZA),
      .ultimo(ultimo)
   );
   // state register, aborts to idle immediately on reset
   always_ff @(posedge clk or negedge reset)
      if (!reset) estado <= REPOSO;
      else estado <= siguiente;
   // next state; start is only looked at in idle and in the done handshake
   always_comb begin
      siguiente = REPOSO;
      case (estado)
         REPOSO:   siguiente = start ? CARGA : REPOSO;
         CARGA:    siguiente = EVALUA;
         EVALUA:   siguiente = DESPLAZA;
         DESPLAZA: siguiente = ultimo ? FIN : EVALUA;
         FIN:      siguiente = start ? FIN : REPOSO;
         default:  siguiente = REPOSO;
      endcase
   end
   // output decode; add/subtract is Mealy on the registered datapath bits
   always_comb begin
      Carga_QM    = estado == CARGA;
      Inicializa  = estado == CARGA;
      Desplaza_AQ = estado == DESPLAZA;
      Carga_A     = estado == EVALUA && (codigo == SUMA || codigo == RESTA);
      Resta       = estado == EVALUA && codigo == RESTA;
      Desplaza_M  = 1'b0;
      Fin         = estado == FIN;
   end
endmodule

// File: tb/tb_uc_booth.sv
// tb_uc_booth: timeline and product checks of the Booth control unit against a cycle-schedule model
module tb_uc_booth;
   localparam int N = 3;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic use_cd = 1'b0;
   logic [1:0] q_drv = 2'b00;
   logic [1:0] qtab [0:31];
   logic q0, q_menos1;
   logic Carga_A, Carga_QM, Inicializa, Desplaza_AQ, Desplaza_M, Resta, Fin;
   logic [6:0] outs;
   logic [3:0] A, M;
   logic [2:0] Q;
   logic qm1;
   logic [2:0] mc, mp;
   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   assign q0 = use_cd ? Q[0] : q_drv[1];
   assign q_menos1 = use_cd ? qm1 : q_drv[0];
   assign outs = {Carga_A, Carga_QM, Inicializa, Desplaza_AQ, Desplaza_M, Resta, Fin};

   uc_booth dut (
      .clk(clk), .reset(reset), .start(start), .q0(q0), .q_menos1(q_menos1),
      .Carga_A(Carga_A), .Carga_QM(Carga_QM), .Inicializa(Inicializa),
      .Desplaza_AQ(Desplaza_AQ), .Desplaza_M(Desplaza_M), .Resta(Resta), .Fin(Fin)
   );

   // datapath stand-in: {A,Q,q-1} registers obeying the control strobes
   always @(posedge clk) begin
      if (Carga_QM) begin
         Q <= mp;
         M <= {mc[2], mc};
      end
      if (Inicializa) begin
         A <= '0;
         qm1 <= 1'b0;
      end
      if (Carga_A) A <= Resta ? A - M : A + M;
      if (Desplaza_AQ) {A, Q, qm1} <= {A[3], A, Q};
   end

   // expected strobes for cycle c after start, from the published schedule
   function automatic logic [6:0] exp_outs(int c, logic q0v, logic qmv, int last);
      logic [6:0] e;
      e = '0;
      if (c == 1) e[5:4] = 2'b11;
      else if (c >= 2 && c <= 2*N && c % 2 == 0) begin
         e[6] = q0v ^ qmv;
         e[1] = q0v & ~qmv;
      end
      else if (c >= 3 && c <= 2*N+1) e[3] = 1'b1;
      else if (c >= 2*N+2 && c <= last) e[0] = 1'b1;
      return e;
   endfunction

   // one full operation: start at cycle 0, random start noise while busy, start held for hold extra cycles in FIN
   task automatic run_op(input bit cdm, input bit rq, input int hold);
      int last;
      int pm;
      logic [1:0] qv;
      logic [6:0] e;
      last = 2*N+2+hold;
      @(negedge clk);
      use_cd = cdm;
      start = 1'b1;
      for (int c = 1; c <= last+2; c++) begin
         @(negedge clk);
         if (c <= 2*N+1) start = 1'($urandom);
         else start = (c < last);
         q_drv = rq ? 2'($urandom) : qtab[c];
         #1;
         qv = cdm ? {Q[0], qm1} : q_drv;
         e = exp_outs(c, qv[1], qv[0], last);
         vectors++;
         if (outs !== e) begin
            miscompares++;
            $display("FAIL strobes cycle %0d: got %b want %b", c, outs, e);
         end
         if (cdm && c == 2*N+2) begin
            pm = $signed(mc) * $signed(mp);
            vectors++;
            if ({A, Q} !== pm[6:0]) begin
               miscompares++;
               $display("FAIL product %0d x %0d: got %b want %b", $signed(mc), $signed(mp), {A, Q}, pm[6:0]);
            end
         end
      end
   endtask

   task automatic test_reset;
      #3;
      vectors++;
      if (outs !== 7'b0) begin
         miscompares++;
         $display("FAIL reset_held: got %b want 0", outs);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      #1;
      vectors++;
      if (outs !== 7'b0) begin
         miscompares++;
         $display("FAIL after_release: got %b want 0", outs);
      end
   endtask

   task automatic test_idle00;
      for (int i = 0; i < 32; i++) qtab[i] = 2'b00;
      run_op(1'b0, 1'b0, 0);
   endtask

   task automatic test_codes;
      for (int i = 0; i < 32; i++) qtab[i] = 2'b11;
      qtab[2] = 2'b10;
      qtab[4] = 2'b01;
      qtab[6] = 2'b00;
      run_op(1'b0, 1'b0, 0);
   endtask

   task automatic test_random_codes;
      for (int k = 0; k < 6; k++) run_op(1'b0, 1'b1, 0);
   endtask

   task automatic test_products;
      logic [5:0] pairs [0:2];
      pairs[0] = {3'b011, 3'b110};
      pairs[1] = {3'b011, 3'b011};
      pairs[2] = {3'b100, 3'b100};
      for (int k = 0; k < 3; k++) begin
         {mc, mp} = pairs[k];
         run_op(1'b1, 1'b0, 0);
      end
      for (int k = 0; k < 10; k++) begin
         mc = 3'($urandom);
         mp = 3'($urandom);
         run_op(1'b1, 1'b0, 0);
      end
   endtask

   task automatic test_handshake;
      mc = 3'b010;
      mp = 3'b101;
      run_op(1'b1, 1'b0, 4);
      run_op(1'b1, 1'b0, 0);
   endtask

   task automatic test_reset_mid;
      mc = 3'b011;
      mp = 3'b011;
      use_cd = 1'b1;
      @(negedge clk);
      start = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      #2;
      reset = 1'b0;
      #1;
      vectors++;
      if (outs !== 7'b0) begin
         miscompares++;
         $display("FAIL reset_mid: got %b want 0", outs);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      #1;
      vectors++;
      if (outs !== 7'b0) begin
         miscompares++;
         $display("FAIL reset_mid_release: got %b want 0", outs);
      end
      run_op(1'b1, 1'b0, 0);
   endtask

   // mutual exclusion and Resta implication hold on every cycle out of reset
   always @(negedge clk) begin
      #2;
      if (reset && ((Carga_A + Carga_QM + Desplaza_AQ) > 1 || (Resta && !Carga_A) || Desplaza_M)) begin
         miscompares++;
         $display("FAIL strobe_exclusion: got %b want one-hot", outs);
      end
   end

   initial begin
      test_reset;
      test_idle00;
      test_codes;
      test_random_codes;
      test_products;
      test_handshake;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
